// File: rtl/tmr0_wdt_ctrl.sv
// TMR0 clock source and prescaler, watchdog timer, and the SLEEP/wake controller.
// Build option: define WDT_TIMER_EN to include the watchdog; otherwise wdtmr stays low.
module tmr0_wdt_ctrl #(
  parameter int WDT_BASE = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       option_wr,
  input  logic [5:0] option_data,
  input  logic       t0cki,
  input  logic       tmr0_wr,
  input  logic       CLRWDT,
  input  logic       SLEEP,
  input  logic       wake_in,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic       sleeping,
  output logic       wake,
  output logic [5:0] option
);

  if (WDT_BASE < 2 || WDT_BASE > 65535) begin : g_base_range
    $error("WDT_BASE must be within 2..65535");
  end

  typedef enum logic {RUN, SLP} state_t;

  state_t     state, state_nxt;
  logic       t0_sync_p0, t0_sync_p1, t0_sync_p2;
  logic [7:0] presc, presc_nxt;
  logic       t0cs, t0se, psa;
  logic [2:0] ps;
  logic       ext_tick, src_tick;
  logic       wdt_clr, wdt_tick, wdt_term;
  logic       presc_clr, tmr0_inc_nxt, wake_nxt;

  // Terminal prescaler counts: 2^(PS+1)-1 toward TMR0, 2^PS-1 toward the watchdog.
  function automatic logic [7:0] tmr0_last(input logic [2:0] sel);
    return 8'hFF >> (3'd7 - sel);
  endfunction

  function automatic logic [7:0] wdt_last(input logic [2:0] sel);
    return 8'h7F >> (3'd7 - sel);
  endfunction

  assign {t0cs, t0se, psa, ps} = option;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      option <= 6'h3F;
    end else if (option_wr) begin
      option <= option_data;
    end
  end

  // t0cki synchronizer: p0/p1 resolve metastability, p2 is the history for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0_sync_p0 <= 1'b0;
      t0_sync_p1 <= 1'b0;
      t0_sync_p2 <= 1'b0;
    end else begin
      t0_sync_p0 <= t0cki;
      t0_sync_p1 <= t0_sync_p0;
      t0_sync_p2 <= t0_sync_p1;
    end
  end

  assign ext_tick = t0se ? (t0_sync_p2 & ~t0_sync_p1) : (~t0_sync_p2 & t0_sync_p1);
  // The internal clock already stops in the cycle that executes SLEEP.
  assign src_tick = t0cs ? ext_tick : ((state == RUN) && !SLEEP);
  assign wdt_clr  = CLRWDT | SLEEP;

`ifdef WDT_TIMER_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_BASE - 1);

  logic [15:0] wdt_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_base <= '0;
    end else if (wdt_clr || (wdt_base == WDT_LAST)) begin
      wdt_base <= '0;
    end else begin
      wdt_base <= wdt_base + 16'd1;
    end
  end

  assign wdt_tick = (wdt_base == WDT_LAST) && !wdt_clr;
`else
  assign wdt_tick = 1'b0;
`endif

  assign presc_clr = option_wr | (~psa & tmr0_wr) | (psa & wdt_clr);

  always_comb begin
    presc_nxt    = presc;
    tmr0_inc_nxt = psa & src_tick;
    wdt_term     = ~psa & wdt_tick;
    if (presc_clr) begin
      presc_nxt = '0;
    end else if (!psa && src_tick) begin
      if (presc == tmr0_last(ps)) begin
        presc_nxt    = '0;
        tmr0_inc_nxt = 1'b1;
      end else begin
        presc_nxt = presc + 8'd1;
      end
    end else if (psa && wdt_tick) begin
      if (presc == wdt_last(ps)) begin
        presc_nxt = '0;
        wdt_term  = 1'b1;
      end else begin
        presc_nxt = presc + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wake_nxt  = 1'b0;
    case (state)
      RUN: if (SLEEP) state_nxt = SLP;
      SLP: begin
        if (wdt_term || wake_in) begin
          state_nxt = RUN;
          wake_nxt  = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Registered strobes: each appears the cycle after its causing event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      tmr0_inc <= 1'b0;
      wdtmr    <= 1'b0;
      wake     <= 1'b0;
    end else begin
      presc    <= presc_nxt;
      tmr0_inc <= tmr0_inc_nxt;
      wdtmr    <= wdt_term;
      wake     <= wake_nxt;
    end
  end

  assign sleeping = (state == SLP);

endmodule

// File: tb/tb_tmr0_wdt_ctrl.sv
// Self-checking bench for tmr0_wdt_ctrl: directed scenarios plus a randomized run
// against a behavioural model. Watchdog scenarios follow the WDT_TIMER_EN build.
module tb_tmr0_wdt_ctrl;

  localparam int WDT_BASE = 16;
`ifdef WDT_TIMER_EN
  localparam int WAKE_WAIT = 8;
`else
  localparam int WAKE_WAIT = 100;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       option_wr = 1'b0;
  logic [5:0] option_data = 6'h00;
  logic       t0cki = 1'b0;
  logic       tmr0_wr = 1'b0;
  logic       CLRWDT = 1'b0;
  logic       SLEEP = 1'b0;
  logic       wake_in = 1'b0;
  logic       tmr0_inc, wdtmr, sleeping, wake;
  logic [5:0] option;

  int checks = 0;
  int passed = 0;

  tmr0_wdt_ctrl #(.WDT_BASE(WDT_BASE)) dut (
    .clk(clk), .rst(rst), .option_wr(option_wr), .option_data(option_data),
    .t0cki(t0cki), .tmr0_wr(tmr0_wr), .CLRWDT(CLRWDT), .SLEEP(SLEEP),
    .wake_in(wake_in), .tmr0_inc(tmr0_inc), .wdtmr(wdtmr), .sleeping(sleeping),
    .wake(wake), .option(option)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    option_wr = 1'b0; option_data = 6'h00; tmr0_wr = 1'b0; CLRWDT = 1'b0;
    SLEEP = 1'b0; wake_in = 1'b0; t0cki = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic write_option(input logic [5:0] v);
    option_data = v;
    option_wr = 1'b1;
    cyc();
    option_wr = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({option, tmr0_inc, wdtmr, wake, sleeping} !== {6'h3F, 4'b0000})
      $display("FAIL reset_state: got %h want %h", {option, tmr0_inc, wdtmr, wake, sleeping}, {6'h3F, 4'b0000});
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    write_option(6'h01);
    repeat (4) cyc();
    checks++;
    if (tmr0_inc !== 1'b1) $display("FAIL pre_reset_pulse: got %b want 1", tmr0_inc);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({option, tmr0_inc, wdtmr, wake, sleeping} !== {6'h3F, 4'b0000})
      $display("FAIL async_reset: got %h want %h", {option, tmr0_inc, wdtmr, wake, sleeping}, {6'h3F, 4'b0000});
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    write_option(6'h01);
    first = 0;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      if (tmr0_inc === 1'b1 && first == 0) first = n;
    end
    checks++;
    if (first != 4) $display("FAIL restart_first_pulse: got %0d want 4", first);
    else passed++;
  endtask

  task automatic test_tmr0_prescale();
    do_reset();
    write_option(6'h01);
    checks++;
    if (option !== 6'h01) $display("FAIL option_load: got %h want 01", option);
    else passed++;
    for (int n = 1; n <= 16; n++) begin
      cyc();
      checks++;
      if (tmr0_inc !== ((n % 4) == 0))
        $display("FAIL prescale_1to4 cycle %0d: got %b want %b", n, tmr0_inc, ((n % 4) == 0));
      else passed++;
    end
  endtask

  task automatic test_ext_clock();
    int total, lat;
    do_reset();
    write_option(6'h38);
    total = 0;
    for (int p = 0; p < 5; p++) begin
      t0cki = 1'b1;
      repeat (6) begin
        cyc();
        if (tmr0_inc === 1'b1) total++;
      end
      t0cki = 1'b0;
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        cyc();
        if (tmr0_inc === 1'b1) begin
          total++;
          if (lat == 0) lat = n;
        end
      end
      checks++;
      if (lat < 3 || lat > 4) $display("FAIL ext_fall_latency pulse %0d: got %0d want 3..4", p, lat);
      else passed++;
    end
    checks++;
    if (total != 5) $display("FAIL ext_pulse_count: got %0d want 5", total);
    else passed++;
  endtask

`ifdef WDT_TIMER_EN
  task automatic test_wdt_timeout();
    int first, second, cnt;
    do_reset();
    write_option(6'h0A);
    first = 0; second = 0; cnt = 0;
    for (int c = 2; c <= 130; c++) begin
      cyc();
      if (wdtmr === 1'b1) begin
        cnt++;
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
    end
    checks++;
    if (first != 64) $display("FAIL wdt_first: got %0d want 64", first);
    else passed++;
    checks++;
    if (second != 128) $display("FAIL wdt_repeat: got %0d want 128", second);
    else passed++;
    checks++;
    if (cnt != 2) $display("FAIL wdt_count: got %0d want 2", cnt);
    else passed++;
  endtask

  task automatic test_wdt_clear();
    int first, cnt;
    do_reset();
    write_option(6'h0A);
    first = 0; cnt = 0;
    for (int c = 2; c <= 130; c++) begin
      CLRWDT = (c == 60);
      cyc();
      if (wdtmr === 1'b1) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    CLRWDT = 1'b0;
    checks++;
    if (first != 124) $display("FAIL clrwdt_next: got %0d want 124", first);
    else passed++;
    checks++;
    if (cnt != 1) $display("FAIL clrwdt_count: got %0d want 1", cnt);
    else passed++;
  endtask

  task automatic test_sleep_wdt();
    int inc_cnt, wdt_at, wake_at;
    logic slp15, slp16;
    do_reset();
    write_option(6'h08);
    cyc();
    checks++;
    if (tmr0_inc !== 1'b1) $display("FAIL awake_internal_tick: got %b want 1", tmr0_inc);
    else passed++;
    SLEEP = 1'b1;
    cyc();
    SLEEP = 1'b0;
    checks++;
    if (sleeping !== 1'b1) $display("FAIL sleep_enter: got %b want 1", sleeping);
    else passed++;
    inc_cnt = 0; wdt_at = 0; wake_at = 0; slp15 = 1'b0; slp16 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (n <= 16 && tmr0_inc === 1'b1) inc_cnt++;
      if (wdtmr === 1'b1 && wdt_at == 0) wdt_at = n;
      if (wake === 1'b1 && wake_at == 0) wake_at = n;
      if (n == 15) slp15 = sleeping;
      if (n == 16) slp16 = sleeping;
    end
    checks++;
    if (inc_cnt != 0) $display("FAIL sleep_no_tick: got %0d want 0", inc_cnt);
    else passed++;
    checks++;
    if (wdt_at != 16) $display("FAIL sleep_wdt_at: got %0d want 16", wdt_at);
    else passed++;
    checks++;
    if (wake_at != 16) $display("FAIL sleep_wake_at: got %0d want 16", wake_at);
    else passed++;
    checks++;
    if ({slp15, slp16} !== 2'b10) $display("FAIL sleep_exit: got %b want 10", {slp15, slp16});
    else passed++;
  endtask
`endif

  task automatic test_sleep_wake_in();
    int awake_cnt, inc_cnt, wdt_cnt, wake_cnt, wake_at;
    do_reset();
    write_option(6'h08);
    SLEEP = 1'b1;
    cyc();
    SLEEP = 1'b0;
    checks++;
    if (sleeping !== 1'b1) $display("FAIL wake_in_sleep_enter: got %b want 1", sleeping);
    else passed++;
    awake_cnt = 0; inc_cnt = 0; wdt_cnt = 0;
    for (int n = 1; n <= WAKE_WAIT; n++) begin
      SLEEP = (n == 4);
      cyc();
      if (sleeping !== 1'b1) awake_cnt++;
      if (tmr0_inc === 1'b1) inc_cnt++;
      if (wdtmr === 1'b1) wdt_cnt++;
    end
    SLEEP = 1'b0;
    checks++;
    if (awake_cnt != 0) $display("FAIL sleep_held: got %0d awake cycles want 0", awake_cnt);
    else passed++;
    checks++;
    if (inc_cnt != 0) $display("FAIL sleep_inc: got %0d want 0", inc_cnt);
    else passed++;
    wake_in = 1'b1;
    wake_cnt = 0; wake_at = 0;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      if (wdtmr === 1'b1) wdt_cnt++;
      if (wake === 1'b1) begin
        wake_cnt++;
        if (wake_at == 0) wake_at = n;
      end
    end
    wake_in = 1'b0;
    checks++;
    if (wdt_cnt != 0) $display("FAIL sleep_wdtmr: got %0d want 0", wdt_cnt);
    else passed++;
    checks++;
    if (wake_cnt != 1 || wake_at != 1) $display("FAIL wake_pulse: got count %0d at %0d want 1 at 1", wake_cnt, wake_at);
    else passed++;
    checks++;
    if (sleeping !== 1'b0) $display("FAIL wake_exit: got %b want 0", sleeping);
    else passed++;
  endtask

  task automatic test_random();
    logic [5:0] m_opt;
    int m_pre, ps, shown;
    bit m_slp, d0, d1, d2, ext, tick, wclr, wt, e_inc, e_wdt, e_wake;
`ifdef WDT_TIMER_EN
    int m_base;
    m_base = 0;
`endif
    do_reset();
    m_opt = 6'h3F; m_pre = 0; m_slp = 1'b0; d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; shown = 0;
    for (int i = 0; i < 3000; i++) begin
      option_wr = ($urandom_range(31) == 0);
      option_data = 6'($urandom);
      tmr0_wr = ($urandom_range(15) == 0);
      CLRWDT = ($urandom_range(39) == 0);
      SLEEP = ($urandom_range(59) == 0);
      wake_in = ($urandom_range(24) == 0);
      if ($urandom_range(2) == 0) t0cki = ~t0cki;
      cyc();
      ps = int'(m_opt[2:0]);
      ext = m_opt[4] ? (d2 && !d1) : (!d2 && d1);
      tick = m_opt[5] ? ext : (!m_slp && !SLEEP);
      wclr = CLRWDT || SLEEP;
      wt = 1'b0;
      e_inc = 1'b0; e_wdt = 1'b0; e_wake = 1'b0;
`ifdef WDT_TIMER_EN
      if (wclr) m_base = 0;
      else if (m_base == WDT_BASE - 1) begin
        m_base = 0;
        wt = 1'b1;
      end else m_base++;
`endif
      if (!m_opt[3]) begin
        if (option_wr || tmr0_wr) m_pre = 0;
        else if (tick) begin
          m_pre++;
          if (m_pre == (2 << ps)) begin
            m_pre = 0;
            e_inc = 1'b1;
          end
        end
        e_wdt = wt;
      end else begin
        e_inc = tick;
        if (option_wr || wclr) m_pre = 0;
        else if (wt) begin
          m_pre++;
          if (m_pre == (1 << ps)) begin
            m_pre = 0;
            e_wdt = 1'b1;
          end
        end
      end
      if (!m_slp) m_slp = SLEEP;
      else if (e_wdt || wake_in) begin
        m_slp = 1'b0;
        e_wake = 1'b1;
      end
      if (option_wr) m_opt = option_data;
      d2 = d1; d1 = d0; d0 = t0cki;
      checks++;
      if ({tmr0_inc, wdtmr, wake} !== {e_inc, e_wdt, e_wake}) begin
        if (shown < 8) $display("FAIL random_strobes cycle %0d: got %b want %b", i, {tmr0_inc, wdtmr, wake}, {e_inc, e_wdt, e_wake});
        shown++;
      end else passed++;
      checks++;
      if ({sleeping, option} !== {m_slp, m_opt}) begin
        if (shown < 8) $display("FAIL random_state cycle %0d: got %h want %h", i, {sleeping, option}, {m_slp, m_opt});
        shown++;
      end else passed++;
    end
    option_wr = 1'b0; tmr0_wr = 1'b0; CLRWDT = 1'b0; SLEEP = 1'b0; wake_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tmr0_prescale();
    test_ext_clock();
`ifdef WDT_TIMER_EN
    test_wdt_timeout();
    test_wdt_clear();
    test_sleep_wdt();
`endif
    test_sleep_wake_in();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tmr0_wdt_ctrl.md
TMR0_WDT_CTRL -- requirements
Module: tmr0_wdt_ctrl

Interface
REQ-001 Parameter WDT_BASE, default 1024: clk cycles per unscaled watchdog tick, range 2..65535.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 option_wr  in  1  load OPTION from option_data this cycle.
REQ-005 option_data  in  6  {T0CS, T0SE, PSA, PS[2:0]}.
REQ-006 t0cki  in  1  external TMR0 clock pin, asynchronous.
REQ-007 tmr0_wr  in  1  core is writing TMR0 this cycle.
REQ-008 CLRWDT  in  1  CLRWDT instruction executing, one-cycle pulse.
REQ-009 SLEEP  in  1  SLEEP instruction executing, one-cycle pulse.
REQ-010 wake_in  in  1  external wake request, level.
REQ-011 tmr0_inc  out  1  one-cycle TMR0 increment strobe to the register file.
REQ-012 wdtmr  out  1  one-cycle watchdog timeout strobe.
REQ-013 sleeping  out  1  high while in SLEEP state.
REQ-014 wake  out  1  one-cycle strobe on leaving SLEEP.
REQ-015 option  out  6  current OPTION value.

Function
REQ-016 OPTION loads on option_wr at next posedge; option_wr also clears the prescaler that cycle.
REQ-017 Source tick: T0CS=0 -> every clk while not sleeping; T0CS=1 -> t0cki through 2-flop synchronizer, edge detect on synchronized value (T0SE=0 rising, T0SE=1 falling); external ticks continue in SLEEP.
REQ-018 8-bit prescaler counter shared: PSA=0 assigns it to TMR0, PSA=1 to WDT.
REQ-019 PSA=0: each source tick increments prescaler; on the tick where prescaler == 2^(PS+1)-1 it wraps to 0 and tmr0_inc pulses the following cycle (ratio 1:2^(PS+1), 1:2..1:256).
REQ-020 PSA=1: tmr0_inc pulses the cycle after each source tick (1:1).
REQ-021 WDT base counter (16-bit) counts every clk, wraps at WDT_BASE-1 producing wdt_tick.
REQ-022 PSA=0: wdt_tick directly causes wdtmr; PSA=1: wdt_tick increments prescaler, wdtmr at 2^PS ticks (PS=0 -> every wdt_tick, 1:1..1:128), prescaler wraps to 0.
REQ-023 wdtmr asserts one cycle after the terminal event; base counter and (PSA=1) prescaler are zero after timeout.
REQ-024 CLRWDT or SLEEP clears WDT base counter, and the prescaler when PSA=1; clear beats a coincident terminal event (no wdtmr).
REQ-025 tmr0_wr with PSA=0 clears prescaler; coincident source tick is discarded.
REQ-026 FSM states RUN, SLP: RUN->SLP on SLEEP; SLP->RUN on wdtmr or wake_in, wake pulsing that same transition cycle; wdtmr and wake_in together yield one wake pulse.
REQ-027 SLEEP while already in SLP is ignored except for its clear effect.
REQ-028 option_wr and tmr0_wr in the same cycle: both clear effects apply, OPTION takes new value.

Reset
REQ-029 rst asynchronously forces: option=6'h3F, prescaler=0, WDT base=0, synchronizer flops=0, FSM=RUN, tmr0_inc=0, wdtmr=0, wake=0, sleeping=0.
REQ-030 rst asserted mid-count discards all partial counts; first tick counting restarts from zero after deassertion.

Configuration
REQ-031 Macro WDT_TIMER_EN defined: watchdog per REQ-021..024 present.
REQ-032 WDT_TIMER_EN undefined: WDT base counter omitted, wdtmr tied 0, PSA=1 prescaler idle, SLP exits only via wake_in; all else unchanged.

Verification
REQ-033 Reset, write option 6'h01 (internal, PSA=0, PS=1) -> tmr0_inc every 4th clk, first pulse 4 clk after option_wr.
REQ-034 option 6'h38 (T0CS=1, T0SE=1, PSA=1), toggle t0cki 5 times -> exactly 5 tmr0_inc, each 3-4 clk after falling edge.
REQ-035 WDT_BASE=16, option 6'h0A (PSA=1, PS=2), no CLRWDT -> wdtmr at cycle 64 after reset release, repeats every 64.
REQ-036 Same config, CLRWDT at cycle 60 -> no wdtmr at 64; next at cycle 124.
REQ-037 SLEEP in RUN, option 6'h08, WDT_BASE=16 -> sleeping=1, no internal tmr0_inc, wdtmr+wake after 16 cycles, sleeping=0.
REQ-038 Build without WDT_TIMER_EN, SLEEP then wake_in=1 after 100 cycles -> wdtmr never asserts, wake pulses once, sleeping clears.
